// File: rtl/light_interval_timer.sv
// light_interval_timer: programmable seconds timer on the timer side of the
// traffic-light controller handshake. A rising edge on start_timer loads the
// duration selected by interval, counts it down in TICK_DIV-cycle seconds and
// returns a single-cycle expired pulse. Durations are reprogrammed via prog_sync.
// Optional feature macro: TIMER_PAUSE_EN adds a pause input that freezes counting.
module light_interval_timer #(
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned DEF_BASE = 6,
   parameter int unsigned DEF_EXT  = 3,
   parameter int unsigned DEF_YEL  = 2
) (
   input  logic             clk,
   input  logic             g_reset,
   input  logic             start_timer,
   input  logic [1:0]       interval,
   input  logic             prog_sync,
   input  logic [1:0]       time_sel,
   input  logic [CNT_W-1:0] time_value,
`ifdef TIMER_PAUSE_EN
   input  logic             pause,
`endif
   output logic             expired,
   output logic             busy,
   output logic [CNT_W-1:0] remaining
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] BASE_DEF  = CNT_W'(DEF_BASE);
   localparam logic [CNT_W-1:0] EXT_DEF   = CNT_W'(DEF_EXT);
   localparam logic [CNT_W-1:0] YEL_DEF   = CNT_W'(DEF_YEL);

   typedef enum logic {StIdle, StCount} state_t;

   state_t           state_q, state_d;
   logic             start_q;
   logic [PW-1:0]    prescaler_q, prescaler_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             busy_q, busy_d;
   logic             expired_q, expired_d;
   logic [CNT_W-1:0] base_q, base_d;
   logic [CNT_W-1:0] ext_q, ext_d;
   logic [CNT_W-1:0] yel_q, yel_d;

   logic             start_edge;
   logic             tick;
   logic             hold;
   logic [CNT_W-1:0] load_val;

   assign start_edge = start_timer & ~start_q;
   assign tick       = (prescaler_q == TICK_LAST);

`ifdef TIMER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign expired   = expired_q;
   assign busy      = busy_q;
   assign remaining = remaining_q;

   // Select the duration to load on a start edge; interval 11 loads zero.
   always_comb begin
      load_val = '0;
      case (interval)
         2'b00:   load_val = base_q;
         2'b01:   load_val = ext_q;
         2'b10:   load_val = yel_q;
         default: load_val = '0;
      endcase
   end

   // Next-state: programming beats a start edge, a start edge beats counting.
   always_comb begin
      state_d     = state_q;
      prescaler_d = prescaler_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      expired_d   = 1'b0;
      base_d      = base_q;
      ext_d       = ext_q;
      yel_d       = yel_q;

      if (prog_sync) begin
         // A zero value restores that register's default.
         case (time_sel)
            2'b00:   base_d = (time_value == '0) ? BASE_DEF : time_value;
            2'b01:   ext_d  = (time_value == '0) ? EXT_DEF  : time_value;
            2'b10:   yel_d  = (time_value == '0) ? YEL_DEF  : time_value;
            default: ;
         endcase
         state_d     = StIdle;
         busy_d      = 1'b0;
         remaining_d = '0;
         prescaler_d = '0;
      end else if (start_edge) begin
         remaining_d = load_val;
         prescaler_d = '0;
         if (load_val != '0) begin
            state_d = StCount;
            busy_d  = 1'b1;
         end else begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            expired_d = 1'b1;
         end
      end else if (state_q == StCount && !hold) begin
         if (tick) begin
            prescaler_d = '0;
            if (remaining_q == CNT_W'(1)) begin
               remaining_d = '0;
               busy_d      = 1'b0;
               state_d     = StIdle;
               expired_d   = 1'b1;
            end else begin
               remaining_d = remaining_q - 1'b1;
            end
         end else begin
            prescaler_d = prescaler_q + 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!g_reset) begin
         state_q     <= StIdle;
         start_q     <= 1'b0;
         prescaler_q <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         expired_q   <= 1'b0;
         base_q      <= BASE_DEF;
         ext_q       <= EXT_DEF;
         yel_q       <= YEL_DEF;
      end else begin
         state_q     <= state_d;
         start_q     <= start_timer;
         prescaler_q <= prescaler_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         expired_q   <= expired_d;
         base_q      <= base_d;
         ext_q       <= ext_d;
         yel_q       <= yel_d;
      end
   end

endmodule

// File: tb/tb_light_interval_timer.sv
// Self-checking bench for light_interval_timer: directed vector table,
// hand-written corner sequences and randomized stimulus against a
// behavioural model. Exercises the pause input when TIMER_PAUSE_EN is defined.
module tb_light_interval_timer;

   localparam int TD = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          g_reset = 1'b0;
   logic          start_timer = 1'b0;
   logic [1:0]    interval = 2'b00;
   logic          prog_sync = 1'b0;
   logic [1:0]    time_sel = 2'b11;
   logic [CW-1:0] time_value = '0;
`ifdef TIMER_PAUSE_EN
   logic          pause = 1'b0;
`endif
   logic          expired;
   logic          busy;
   logic [CW-1:0] remaining;

   int tests = 0;
   int fails = 0;

   light_interval_timer #(
      .TICK_DIV(TD), .CNT_W(CW), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)
   ) dut (
      .clk        (clk),
      .g_reset    (g_reset),
      .start_timer(start_timer),
      .interval   (interval),
      .prog_sync  (prog_sync),
      .time_sel   (time_sel),
      .time_value (time_value),
`ifdef TIMER_PAUSE_EN
      .pause      (pause),
`endif
      .expired    (expired),
      .busy       (busy),
      .remaining  (remaining)
   );

   always #5 clk = ~clk;

   // Behavioural model: a count is "elapsed unpaused cycles since the start edge".
   int m_def [3] = '{6, 3, 2};
   int m_dur [3] = '{6, 3, 2};
   bit m_prev = 0, m_active = 0, m_exp = 0;
   int m_n = 0, m_e = 0;

   function automatic int m_rem();
      return m_active ? (m_n - m_e / TD) : 0;
   endfunction

   task automatic model_update();
      bit edge_s, frozen;
      int n;
      edge_s = start_timer && !m_prev;
      frozen = 0;
`ifdef TIMER_PAUSE_EN
      frozen = pause;
`endif
      m_exp = 0;
      if (!g_reset) begin
         m_dur = m_def;
         m_prev = 0;
         m_active = 0;
         m_n = 0;
         m_e = 0;
         return;
      end
      m_prev = start_timer;
      if (prog_sync) begin
         if (time_sel != 2'b11)
            m_dur[time_sel] = (time_value == 0) ? m_def[time_sel] : int'(time_value);
         m_active = 0;
      end else if (edge_s) begin
         n = (interval == 2'b11) ? 0 : m_dur[interval];
         m_n = n;
         m_e = 0;
         m_active = (n != 0);
         m_exp = (n == 0);
      end else if (m_active && !frozen) begin
         m_e++;
         if (m_e == m_n * TD) begin
            m_active = 0;
            m_exp = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      tests++;
      if (expired !== m_exp || busy !== m_active || int'(remaining) != m_rem()) begin
         fails++;
         $display("FAIL model @%0t: expired=%0b want %0b, busy=%0b want %0b, remaining=%0d want %0d",
                  $time, expired, m_exp, busy, m_active, remaining, m_rem());
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      g_reset = 1'b0;
      start_timer = 1'b0;
      prog_sync = 1'b0;
      step();
      step();
      g_reset = 1'b1;
      step();
   endtask

   typedef struct {
      bit       do_prog;
      bit [1:0] sel;
      int       val;
      bit [1:0] intv;
      int       rem0;
      int       lat;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat, cnt;

      // Expected latency = edges after the start edge until expired is seen.
      vecs[0] = '{0, 2'b11, 0,  2'b00, 6,  24};
      vecs[1] = '{1, 2'b01, 5,  2'b01, 5,  20};
      vecs[2] = '{1, 2'b10, 0,  2'b10, 2,  8};
      vecs[3] = '{0, 2'b11, 0,  2'b11, 0,  0};
      vecs[4] = '{1, 2'b00, 1,  2'b00, 1,  4};
      vecs[5] = '{1, 2'b11, 9,  2'b01, 5,  20};
      vecs[6] = '{1, 2'b00, 15, 2'b00, 15, 60};
      vecs[7] = '{0, 2'b11, 0,  2'b10, 2,  8};

      // Reset state, with start held high across reset release.
      g_reset = 1'b0;
      start_timer = 1'b1;
      interval = 2'b00;
      step();
      step();
      chk("reset_state", {31'd0, expired} + {31'd0, busy} + int'(remaining), 0);
      g_reset = 1'b1;
      step();
      chk("start_across_reset", int'(busy) * 100 + int'(remaining), 106);
      repeat (30) step();

      // Vector table.
      foreach (vecs[i]) begin
         start_timer = 1'b0;
         step();
         if (vecs[i].do_prog) begin
            prog_sync = 1'b1;
            time_sel = vecs[i].sel;
            time_value = CW'(vecs[i].val);
            step();
            prog_sync = 1'b0;
         end
         interval = vecs[i].intv;
         start_timer = 1'b1;
         step();
         chk($sformatf("vec%0d_load", i), int'(busy) * 100 + int'(remaining),
             (vecs[i].rem0 != 0 ? 100 : 0) + vecs[i].rem0);
         lat = -1;
         for (int k = 0; k < 100; k++) begin
            if (expired) begin
               lat = k;
               break;
            end
            step();
         end
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         step();
         chk($sformatf("vec%0d_single_pulse", i), int'(expired) + int'(busy), 0);
      end

      // Restart mid-count: only the second count may expire.
      do_reset();
      start_timer = 1'b1;
      interval = 2'b00;
      step();
      repeat (9) step();
      start_timer = 1'b0;
      step();
      interval = 2'b10;
      start_timer = 1'b1;
      step();
      cnt = 0;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (expired) begin
            cnt++;
            lat = k;
         end
      end
      chk("restart_pulses", cnt, 1);
      chk("restart_latency", lat, 8);

      // prog_sync during a count aborts it without a pulse.
      start_timer = 1'b0;
      step();
      interval = 2'b00;
      start_timer = 1'b1;
      step();
      repeat (4) step();
      prog_sync = 1'b1;
      time_sel = 2'b11;
      step();
      prog_sync = 1'b0;
      chk("prog_abort_state", int'(busy) + int'(remaining), 0);
      cnt = 0;
      repeat (30) begin
         step();
         cnt += int'(expired);
      end
      chk("prog_abort_no_pulse", cnt, 0);

      // prog_sync and start edge together: the edge is dropped.
      start_timer = 1'b0;
      step();
      start_timer = 1'b1;
      prog_sync = 1'b1;
      step();
      prog_sync = 1'b0;
      cnt = 0;
      repeat (10) begin
         step();
         cnt += int'(expired) + int'(busy);
      end
      chk("prog_beats_start", cnt, 0);

      // Reset mid-count: no pulse afterwards.
      start_timer = 1'b0;
      step();
      start_timer = 1'b1;
      step();
      repeat (5) step();
      g_reset = 1'b0;
      start_timer = 1'b0;
      step();
      chk("reset_midcount", int'(busy) + int'(remaining) + int'(expired), 0);
      g_reset = 1'b1;
      cnt = 0;
      repeat (30) begin
         step();
         cnt += int'(expired);
      end
      chk("reset_no_pulse", cnt, 0);

`ifdef TIMER_PAUSE_EN
      // Pausing 8 cycles delays expiry by exactly 8 cycles.
      start_timer = 1'b0;
      interval = 2'b00;
      step();
      start_timer = 1'b1;
      step();
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         pause = (k >= 5 && k <= 12);
         step();
         if (expired) begin
            lat = k;
            break;
         end
      end
      pause = 1'b0;
      chk("pause_latency", lat, 32);
`endif

      // Randomized stimulus against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(5) == 0) start_timer = ~start_timer;
         interval = 2'($urandom_range(3));
         prog_sync = ($urandom_range(39) == 0);
         time_sel = 2'($urandom_range(3));
         time_value = CW'($urandom_range(15));
         g_reset = ($urandom_range(299) != 0);
`ifdef TIMER_PAUSE_EN
         pause = ($urandom_range(3) == 0);
`endif
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
